stream_demux_reg: RTL and testbench
===================================

Name: stream_demux_reg

Overview:
Registered 1-to-N stream demultiplexer, the routing counterpart of the mux primitive. It steers one valid/ready upstream stream to one of N_OUT downstream lanes selected per transfer. Each lane has a one-entry output register, so latency is one cycle and back-pressure on one lane does not block transfers to the other lanes. It sits between a single producer and several independent consumers in the homework datapath blocks.

Parameters:
WIDTH, 8, data width in bits
N_OUT, 4, number of downstream lanes (2..16, need not be a power of two)
SEL_W, $clog2(N_OUT), width of up_sel (derived; do not override)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
up_valid  input  1  upstream word present
up_ready  output  1  upstream word accepted this cycle when up_valid && up_ready
up_data  input  WIDTH  upstream payload
up_sel  input  SEL_W  destination lane index
down_valid  output  N_OUT  per-lane valid, bit i = lane i
down_ready  input  N_OUT  per-lane ready
down_data  output  N_OUT*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
drop_cnt  output  8  saturating count of words with out-of-range up_sel

Behaviour:
- Reset (rst=1 at a clk edge): all down_valid=0, all down_data=0, drop_cnt=0. Reset wins over any same-cycle transfer. A word held in a lane during reset is discarded.
- Per-lane state: full flag (drives down_valid[i]) and data register.
- Lane drain: down_valid[i] && down_ready[i] -> lane i frees at the edge unless it is refilled in the same cycle.
- Lane can accept: !full[i] || down_ready[i], which allows simultaneous drain and refill for full throughput.
- up_ready is combinational. For in-range up_sel it equals "lane up_sel can accept". For up_sel >= N_OUT it is 1. It must not depend on up_valid.
- Accept with in-range sel: at the edge, lane up_sel loads up_data and full=1. down_valid rises 1 cycle after acceptance (latency 1).
- Accept with up_sel >= N_OUT: the word is discarded and no lane changes. drop_cnt increments and saturates at 255.
- Simultaneous drain of lane j and refill of lane j: the new data is loaded and down_valid[j] stays 1 with no bubble.
- Lanes other than up_sel are unaffected by upstream activity and drain independently.
- Stability: while down_valid[i]=1 and down_ready[i]=0, down_data lane i holds its value.
- up_valid=0: no state change except drains.
- Ordering: words to the same lane leave in acceptance order. There is no ordering guarantee across lanes.
- No combinational path from down_ready to down_valid/down_data. The only combinational paths are down_ready[up_sel] -> up_ready and up_sel -> up_ready.
- Implementation: generate loop over lanes, one always_ff per lane plus one for drop_cnt, no latches.

Test Plan:
- Reset/idle: assert rst 2 cycles with up_valid=1 -> down_valid=0000, down_data=0, drop_cnt=0, no load during reset.
- Basic routing: all down_ready=1; send 0x11 sel0, 0x22 sel1, 0x33 sel2, 0x44 sel3 on consecutive cycles -> each appears on its lane exactly 1 cycle after acceptance; up_ready stays 1 throughout.
- Back-pressure isolation: down_ready[2]=0; send 0xA0 sel2, then 0xA1 sel2 and 0xB0 sel1 -> lane2 holds 0xA0, up_ready=0 while sel=2; the sel1 word is accepted and emitted. Releasing down_ready[2] emits 0xA0, then 0xA1.
- Full-throughput refill: lane0 full, down_ready[0]=1, 8 back-to-back words to sel0 -> down_valid[0] continuously 1, 8 words out in order, no bubbles.
- Out-of-range: N_OUT=3, send 300 words with up_sel=3 -> up_ready=1 each cycle, no down_valid activity, drop_cnt=255 (saturated).
- Reset mid-operation: lanes 0 and 3 full and stalled, pulse rst 1 cycle -> down_valid=0000 next cycle, stale data not emitted, the next accepted word routes normally.

Source files
------------

// File: rtl/stream_demux_reg.sv
// Purpose: routes one valid/ready stream to one of N_OUT lanes, each with a one-entry output register.
// Latency: one cycle from upstream acceptance to down_valid on the chosen lane.
// Backpressure: up_ready follows only the selected lane, so a stalled lane never blocks the others.
module stream_demux_reg #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = $clog2(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   up_valid,
    output logic                   up_ready,
    input  logic [WIDTH-1:0]       up_data,
    input  logic [SEL_W-1:0]       up_sel,
    output logic [N_OUT-1:0]       down_valid,
    input  logic [N_OUT-1:0]       down_ready,
    output logic [N_OUT*WIDTH-1:0] down_data,
    output logic [7:0]             drop_cnt
);

    // Per-lane "can take a word this cycle" and "up_sel addresses this lane".
    logic [N_OUT-1:0] can_acc;
    logic [N_OUT-1:0] sel_hit;

    logic       sel_in_range;
    logic       drop;
    logic [7:0] drop_cnt_q;
    logic [7:0] drop_cnt_d;

    // An out-of-range select matches no lane; such words are always accepted and discarded.
    always_comb begin
        up_ready     = 1'b1;
        sel_in_range = 1'b0;
        for (int i = 0; i < N_OUT; i++) begin
            if (sel_hit[i]) begin
                up_ready     = can_acc[i];
                sel_in_range = 1'b1;
            end
        end
    end

    assign drop = up_valid && !sel_in_range;

    for (genvar g = 0; g < N_OUT; g++) begin : g_lane
        logic             full_q;
        logic             full_d;
        logic [WIDTH-1:0] data_q;
        logic [WIDTH-1:0] data_d;
        logic             load;

        assign sel_hit[g] = (up_sel == SEL_W'(g));
        assign can_acc[g] = !full_q || down_ready[g];
        assign load       = up_valid && sel_hit[g] && can_acc[g];

        // Refill takes priority over drain so a lane drained and reloaded in one cycle stays full.
        always_comb begin
            full_d = full_q;
            data_d = data_q;
            if (load) begin
                full_d = 1'b1;
                data_d = up_data;
            end else if (down_ready[g]) begin
                full_d = 1'b0;
            end
        end

        // Lane register: reset discards any held word.
        always_ff @(posedge clk) begin
            if (rst) begin
                full_q <= 1'b0;
                data_q <= '0;
            end else begin
                full_q <= full_d;
                data_q <= data_d;
            end
        end

        assign down_valid[g]                = full_q;
        assign down_data[g*WIDTH +: WIDTH]  = data_q;
    end

    // Saturating counter of discarded out-of-range words.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux_reg.sv
module tb_stream_demux_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        up_valid;
    logic        up_ready;
    logic [7:0]  up_data;
    logic [1:0]  up_sel;
    logic [3:0]  down_valid;
    logic [3:0]  down_ready;
    logic [31:0] down_data;
    logic [7:0]  drop_cnt;

    logic        u3_valid;
    logic        u3_ready;
    logic [7:0]  u3_data;
    logic [1:0]  u3_sel;
    logic [2:0]  d3_valid;
    logic [2:0]  d3_ready;
    logic [23:0] d3_data;
    logic [7:0]  drop3;

    int total = 0;
    int bad   = 0;

    // Reference model: each lane is a FIFO of words owned by that lane (capacity one).
    logic [7:0] lane_q [4][$];

    always #5 clk = ~clk;

    stream_demux_reg #(.WIDTH(8), .N_OUT(4)) dut (
        .clk(clk), .rst(rst),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_sel(up_sel),
        .down_valid(down_valid), .down_ready(down_ready), .down_data(down_data),
        .drop_cnt(drop_cnt)
    );

    stream_demux_reg #(.WIDTH(8), .N_OUT(3)) dut3 (
        .clk(clk), .rst(rst),
        .up_valid(u3_valid), .up_ready(u3_ready), .up_data(u3_data), .up_sel(u3_sel),
        .down_valid(d3_valid), .down_ready(d3_ready), .down_data(d3_data),
        .drop_cnt(drop3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the main DUT against the queue model: inputs are already applied.
    task automatic step();
        int         s;
        logic       exp_rdy;
        logic [7:0] w;
        @(negedge clk);
        s = int'(up_sel);
        exp_rdy = (lane_q[s].size() == 0) || down_ready[s];
        if (!rst) begin
            chk("up_ready", {31'd0, up_ready}, {31'd0, exp_rdy});
            for (int i = 0; i < 4; i++) begin
                if (lane_q[i].size() > 0 && down_ready[i]) begin
                    w = lane_q[i].pop_front();
                    chk($sformatf("drain_lane%0d", i), {24'd0, down_data[i*8 +: 8]}, {24'd0, w});
                end
            end
            if (up_valid && exp_rdy) lane_q[s].push_back(up_data);
        end else begin
            for (int i = 0; i < 4; i++) lane_q[i].delete();
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("valid_lane%0d", i), {31'd0, down_valid[i]},
                {31'd0, lane_q[i].size() > 0});
            if (lane_q[i].size() > 0)
                chk($sformatf("data_lane%0d", i), {24'd0, down_data[i*8 +: 8]}, {24'd0, lane_q[i][0]});
        end
        chk("drop_cnt_main", {24'd0, drop_cnt}, 32'd0);
    endtask

    task automatic send(input logic [1:0] sel, input logic [7:0] data);
        up_valid = 1'b1;
        up_sel   = sel;
        up_data  = data;
        step();
    endtask

    initial begin
        rst = 1'b1; up_valid = 1'b1; up_data = 8'h5A; up_sel = 2'd0; down_ready = 4'h0;
        u3_valid = 1'b0; u3_data = 8'h00; u3_sel = 2'd0; d3_ready = 3'b111;

        // Reset held two cycles with a pending upstream word.
        step();
        step();
        chk("rst_valid", {28'd0, down_valid}, 32'd0);
        chk("rst_data", down_data, 32'd0);
        chk("rst_drop3", {24'd0, drop3}, 32'd0);
        rst = 1'b0;
        up_valid = 1'b0;
        step();

        // Basic routing, all lanes ready.
        down_ready = 4'hF;
        send(2'd0, 8'h11);
        send(2'd1, 8'h22);
        send(2'd2, 8'h33);
        send(2'd3, 8'h44);
        up_valid = 1'b0;
        step();

        // Back-pressure isolation on lane 2.
        down_ready = 4'b1011;
        send(2'd2, 8'hA0);
        send(2'd2, 8'hA1);
        chk("lane2_hold", {24'd0, down_data[23:16]}, 32'h0000_00A0);
        send(2'd1, 8'hB0);
        down_ready = 4'hF;
        send(2'd2, 8'hA1);
        up_valid = 1'b0;
        step();
        step();

        // Full-throughput refill of lane 0.
        send(2'd0, 8'h80);
        for (int k = 1; k < 8; k++) begin
            send(2'd0, 8'h80 + 8'(k));
            chk("no_bubble", {31'd0, down_valid[0]}, 32'd1);
        end
        up_valid = 1'b0;
        step();
        step();

        // Reset while lanes 0 and 3 are full and stalled.
        down_ready = 4'h0;
        send(2'd0, 8'hC0);
        send(2'd3, 8'hC3);
        up_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", {28'd0, down_valid}, 32'd0);
        down_ready = 4'hF;
        send(2'd1, 8'hD1);
        chk("post_rst_route", {28'd0, down_valid}, 32'h2);
        up_valid = 1'b0;
        step();

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            up_valid   = 1'($urandom_range(0, 3) != 0);
            up_sel     = 2'($urandom_range(0, 3));
            up_data    = 8'($urandom);
            down_ready = 4'($urandom);
            step();
        end
        up_valid   = 1'b0;
        down_ready = 4'hF;
        step();
        step();

        // Out-of-range select on the three-lane instance: every word dropped, counter saturates.
        for (int k = 0; k < 300; k++) begin
            u3_valid = 1'b1;
            u3_sel   = 2'd3;
            u3_data  = 8'($urandom);
            d3_ready = 3'($urandom);
            @(negedge clk);
            chk("oor_ready", {31'd0, u3_ready}, 32'd1);
            @(posedge clk);
            #1;
            chk("oor_valid", {29'd0, d3_valid}, 32'd0);
            chk("oor_drop", {24'd0, drop3}, (k + 1 > 255) ? 32'd255 : 32'(k + 1));
        end
        u3_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("oor_sat", {24'd0, drop3}, 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
